// File: rtl/dcache_subsystem_if.sv
// ---------------------------------------------------------------------------
// dcache_subsystem_if
// Pipeline-side bus of the data cache subsystem (MEM stage <-> cache).
//   READ_WRITE [3:0]  : [3] request valid, [0] 1=write/0=read,
//                       [2:1] size 00 byte, 01 word, 10 halfword, 11 word
//   ADDRESS   [31:0]  : byte address
//   WRITEDATA [31:0]  : store data, byte/half taken from the low bits
//   READDATA  [31:0]  : load result, byte/half sign-extended
//   BUSYWAIT          : stall, high while a valid request cannot complete
// master = pipeline side, slave = cache side.
// ---------------------------------------------------------------------------
interface dcache_subsystem_if;
    logic [3:0]  READ_WRITE;
    logic [31:0] ADDRESS;
    logic [31:0] WRITEDATA;
    logic [31:0] READDATA;
    logic        BUSYWAIT;

    modport master (
        output READ_WRITE,
        output ADDRESS,
        output WRITEDATA,
        input  READDATA,
        input  BUSYWAIT
    );

    modport slave (
        input  READ_WRITE,
        input  ADDRESS,
        input  WRITEDATA,
        output READDATA,
        output BUSYWAIT
    );
endinterface

// File: rtl/dcache_subsystem.sv
// ---------------------------------------------------------------------------
// dcache_subsystem
// Direct-mapped, write-back, write-allocate data cache (16 lines x 128-bit
// blocks) together with its block-wide backing memory.
// Ports:
//   CLK    : rising-edge clock
//   RESET  : asynchronous, active-high reset
//   bus    : dcache_subsystem_if.slave (READ_WRITE, ADDRESS, WRITEDATA in;
//            READDATA, BUSYWAIT out)
// Parameters:
//   MEM_LATENCY : cycles the memory is busy on one block read or write (>=1)
//   MEM_BLOCKS  : number of 128-bit memory blocks; upper block-address bits
//                 are ignored, so addresses alias modulo MEM_BLOCKS
// ---------------------------------------------------------------------------
module dcache_subsystem #(
    parameter int MEM_LATENCY = 5,
    parameter int MEM_BLOCKS  = 256
) (
    input logic               CLK,
    input logic               RESET,
    dcache_subsystem_if.slave bus
);
    localparam int MAW = (MEM_BLOCKS > 1) ? $clog2(MEM_BLOCKS) : 1;
    localparam int CW  = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] LAT = CW'(MEM_LATENCY);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, FILL} state_t;

    state_t state, state_next;

    // Cache storage
    logic [127:0] data_arr [16];
    logic [23:0]  tag_arr  [16];
    logic [15:0]  valid_bits;
    logic [15:0]  dirty_bits;

    // The missing line is captured so the fill completes even if the
    // pipeline changes its request mid-miss
    logic [23:0]  miss_tag;
    logic [3:0]   miss_index;
    logic [31:0]  last_rdata;

    // Backing memory
    logic [127:0]  mem [MEM_BLOCKS];
    logic [MAW-1:0] mem_addr;
    logic [127:0]  mem_wdata;
    logic [127:0]  mem_rdata;
    logic          mem_is_write;
    logic [CW-1:0] mem_cnt;
    logic          mem_busy;

    // Control signals from the FSM
    logic           mem_rd_issue;
    logic           mem_wr_issue;
    logic [MAW-1:0] issue_addr;
    logic [127:0]   issue_data;
    logic           latch_miss;
    logic           read_hit;
    logic           write_hit;
    logic           busy;

    // Request decode
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic [23:0] req_tag;
    logic [3:0]  req_index;
    logic [1:0]  req_word;
    logic [1:0]  req_byte;
    logic        hit;
    logic [31:0] cur_word;
    logic [31:0] load_value;
    logic [31:0] merged_word;

    assign req_valid = bus.READ_WRITE[3];
    assign req_write = bus.READ_WRITE[0];
    assign req_size  = bus.READ_WRITE[2:1];
    assign req_tag   = bus.ADDRESS[31:8];
    assign req_index = bus.ADDRESS[7:4];
    assign req_word  = bus.ADDRESS[3:2];
    assign req_byte  = bus.ADDRESS[1:0];

    assign hit      = valid_bits[req_index] && (tag_arr[req_index] == req_tag);
    assign cur_word = data_arr[req_index][{req_word, 5'd0} +: 32];
    assign mem_busy = (mem_cnt != '0);

    // Load formatting: byte and halfword lanes are sign-extended; misaligned
    // offsets are simply truncated to the lane boundary
    always_comb begin
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        byte_sel   = cur_word[{req_byte, 3'd0} +: 8];
        half_sel   = cur_word[{req_byte[1], 4'd0} +: 16];
        load_value = cur_word;
        case (req_size)
            2'b00:   load_value = {{24{byte_sel[7]}}, byte_sel};
            2'b10:   load_value = {{16{half_sel[15]}}, half_sel};
            default: load_value = cur_word;
        endcase
    end

    // Store merge: only the addressed byte/half lane of the word changes
    always_comb begin
        merged_word = cur_word;
        case (req_size)
            2'b00:   merged_word[{req_byte, 3'd0} +: 8]     = bus.WRITEDATA[7:0];
            2'b10:   merged_word[{req_byte[1], 4'd0} +: 16] = bus.WRITEDATA[15:0];
            default: merged_word = bus.WRITEDATA;
        endcase
    end

    // Next-state and control. A dirty victim is written back first; the
    // write-back state holds one extra cycle after the memory finishes so the
    // block read can be issued to an idle memory.
    always_comb begin
        state_next   = state;
        busy         = 1'b0;
        mem_rd_issue = 1'b0;
        mem_wr_issue = 1'b0;
        issue_addr   = MAW'({req_tag, req_index});
        issue_data   = data_arr[req_index];
        latch_miss   = 1'b0;
        read_hit     = 1'b0;
        write_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (hit) begin
                        read_hit  = !req_write;
                        write_hit = req_write;
                    end else begin
                        busy       = 1'b1;
                        latch_miss = 1'b1;
                        if (dirty_bits[req_index]) begin
                            mem_wr_issue = 1'b1;
                            issue_addr   = MAW'({tag_arr[req_index], req_index});
                            state_next   = WRITEBACK;
                        end else begin
                            mem_rd_issue = 1'b1;
                            state_next   = FETCH;
                        end
                    end
                end
            end
            WRITEBACK: begin
                busy = 1'b1;
                if (!mem_busy) begin
                    mem_rd_issue = 1'b1;
                    issue_addr   = MAW'({miss_tag, miss_index});
                    state_next   = FETCH;
                end
            end
            FETCH: begin
                busy = 1'b1;
                if (mem_cnt == CW'(1)) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Stall is suppressed while reset is held so the pipeline sees a quiet bus
    assign bus.BUSYWAIT = busy & ~RESET;
    assign bus.READDATA = read_hit ? load_value : last_rdata;

    // State register plus the line status bits and captured miss address
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            valid_bits <= '0;
            dirty_bits <= '0;
            miss_tag   <= '0;
            miss_index <= '0;
            last_rdata <= '0;
        end else begin
            state <= state_next;
            if (latch_miss) begin
                miss_tag   <= req_tag;
                miss_index <= req_index;
            end
            if (state == FILL) begin
                valid_bits[miss_index] <= 1'b1;
                dirty_bits[miss_index] <= 1'b0;
            end
            if (write_hit) begin
                dirty_bits[req_index] <= 1'b1;
            end
            if (read_hit) begin
                last_rdata <= load_value;
            end
        end
    end

    // Line data and tags need no reset; VALID gates their use
    always_ff @(posedge CLK) begin
        if (state == FILL) begin
            data_arr[miss_index] <= mem_rdata;
            tag_arr[miss_index]  <= miss_tag;
        end
        if (write_hit) begin
            data_arr[req_index][{req_word, 5'd0} +: 32] <= merged_word;
        end
    end

    // Backing memory: latches address/data on issue, stays busy for
    // MEM_LATENCY cycles and performs the transfer on the last busy edge.
    // Reset reloads every word with its own byte address.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int b = 0; b < MEM_BLOCKS; b++) begin
                mem[b] <= {32'(b * 16 + 12), 32'(b * 16 + 8),
                           32'(b * 16 + 4),  32'(b * 16)};
            end
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_rdata    <= '0;
            mem_is_write <= 1'b0;
            mem_cnt      <= '0;
        end else if (mem_rd_issue || mem_wr_issue) begin
            mem_addr     <= issue_addr;
            mem_wdata    <= issue_data;
            mem_is_write <= mem_wr_issue;
            mem_cnt      <= LAT;
        end else if (mem_busy) begin
            mem_cnt <= mem_cnt - CW'(1);
            if (mem_cnt == CW'(1)) begin
                if (mem_is_write) begin
                    mem[mem_addr] <= mem_wdata;
                end else begin
                    mem_rdata <= mem[mem_addr];
                end
            end
        end
    end
endmodule

// File: tb/tb_dcache_subsystem.sv
// ---------------------------------------------------------------------------
// tb_dcache_subsystem
// Self-checking bench for dcache_subsystem: a directed vector table, hand
// sequences for reset-mid-miss and request-change-mid-miss, and a random
// phase checked against a per-access functional model of cache + memory.
// ---------------------------------------------------------------------------
module tb_dcache_subsystem;
    localparam int LAT         = 5;
    localparam int CLEAN_STALL = LAT + 2;
    localparam int DIRTY_STALL = 2 * LAT + 3;
    localparam int STALL_LIMIT = 100;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    dcache_subsystem_if bus();

    dcache_subsystem #(
        .MEM_LATENCY(LAT),
        .MEM_BLOCKS (256)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_stall;
        bit          chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [16];

    // Functional model: flat memory blocks plus per-line state
    logic [31:0] m_mem  [256][4];
    logic [31:0] m_line [16][4];
    logic [23:0] m_tag  [16];
    bit          m_valid[16];
    bit          m_dirty[16];
    logic [31:0] m_last_rd;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one request at a falling edge, count rising edges with BUSYWAIT
    // high, capture READDATA in the completing cycle, then let it commit
    task automatic applyStimulus(input logic [3:0] rw, input logic [31:0] addr,
                                 input logic [31:0] wdata,
                                 output int stall, output logic [31:0] rd);
        @(negedge CLK);
        bus.READ_WRITE = rw;
        bus.ADDRESS    = addr;
        bus.WRITEDATA  = wdata;
        stall = 0;
        #1;
        while (bus.BUSYWAIT && stall < STALL_LIMIT) begin
            @(posedge CLK);
            stall++;
            @(negedge CLK);
            #1;
        end
        rd = bus.READDATA;
        @(posedge CLK);
    endtask

    task automatic idleCheck(input string name, input logic [31:0] exp_rd);
        @(negedge CLK);
        bus.READ_WRITE = 4'b0000;
        bus.ADDRESS    = $urandom;
        bus.WRITEDATA  = $urandom;
        #1;
        checkOutput({name, "_busy"}, 32'(bus.BUSYWAIT), 32'd0);
        checkOutput({name, "_hold"}, bus.READDATA, exp_rd);
        @(posedge CLK);
    endtask

    task automatic modelReset();
        for (int b = 0; b < 256; b++)
            for (int w = 0; w < 4; w++)
                m_mem[b][w] = 32'(b * 16 + w * 4);
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
        m_last_rd = 32'd0;
    endtask

    task automatic modelAccess(input logic [3:0] rw, input logic [31:0] addr,
                               input logic [31:0] wdata,
                               output int exp_stall, output logic [31:0] exp_rd);
        int          idx;
        int          w;
        int          boff;
        int          blk;
        logic [23:0] tag;
        logic [31:0] word;
        logic [7:0]  b8;
        logic [15:0] h16;
        idx  = int'(addr[7:4]);
        w    = int'(addr[3:2]);
        boff = int'(addr[1:0]);
        tag  = addr[31:8];
        exp_stall = 0;
        if (!(m_valid[idx] && m_tag[idx] == tag)) begin
            if (m_dirty[idx]) begin
                blk = (int'(m_tag[idx]) * 16 + idx) % 256;
                for (int k = 0; k < 4; k++) m_mem[blk][k] = m_line[idx][k];
                exp_stall = DIRTY_STALL;
            end else begin
                exp_stall = CLEAN_STALL;
            end
            blk = int'(addr[11:4]);
            for (int k = 0; k < 4; k++) m_line[idx][k] = m_mem[blk][k];
            m_tag[idx]   = tag;
            m_valid[idx] = 1;
            m_dirty[idx] = 0;
        end
        word = m_line[idx][w];
        if (rw[0]) begin
            case (rw[2:1])
                2'b00:   word[boff * 8 +: 8]         = wdata[7:0];
                2'b10:   word[(boff / 2) * 16 +: 16] = wdata[15:0];
                default: word = wdata;
            endcase
            m_line[idx][w] = word;
            m_dirty[idx]   = 1;
            exp_rd = m_last_rd;
        end else begin
            b8  = word[boff * 8 +: 8];
            h16 = word[(boff / 2) * 16 +: 16];
            case (rw[2:1])
                2'b00:   exp_rd = {{24{b8[7]}}, b8};
                2'b10:   exp_rd = {{16{h16[15]}}, h16};
                default: exp_rd = word;
            endcase
            m_last_rd = exp_rd;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          stall;
        logic [31:0] rd;
        logic [3:0]  rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_stall;
        logic [31:0] exp_rd;
        logic [23:0] tags [4];

        vecs[0]  = '{4'b1010, 32'h0000_0000, 32'h0,         CLEAN_STALL, 1'b1, 32'h0000_0000};
        vecs[1]  = '{4'b1010, 32'h0000_0004, 32'h0,         0,           1'b1, 32'h0000_0004};
        vecs[2]  = '{4'b1011, 32'h0000_0000, 32'hABCD_1234, 0,           1'b0, 32'h0};
        vecs[3]  = '{4'b1000, 32'h0000_0000, 32'h0,         0,           1'b1, 32'h0000_0034};
        vecs[4]  = '{4'b1000, 32'h0000_0003, 32'h0,         0,           1'b1, 32'hFFFF_FFAB};
        vecs[5]  = '{4'b1010, 32'h0000_0100, 32'h0,         DIRTY_STALL, 1'b1, 32'h0000_0100};
        vecs[6]  = '{4'b1010, 32'h0000_0000, 32'h0,         CLEAN_STALL, 1'b1, 32'hABCD_1234};
        vecs[7]  = '{4'b1101, 32'h0000_0022, 32'h0000_BEEF, CLEAN_STALL, 1'b0, 32'h0};
        vecs[8]  = '{4'b1010, 32'h0000_0020, 32'h0,         0,           1'b1, 32'hBEEF_0020};
        vecs[9]  = '{4'b1100, 32'h0000_0022, 32'h0,         0,           1'b1, 32'hFFFF_BEEF};
        vecs[10] = '{4'b1110, 32'h0000_0024, 32'h0,         0,           1'b1, 32'h0000_0024};
        vecs[11] = '{4'b1010, 32'h0000_0027, 32'h0,         0,           1'b1, 32'h0000_0024};
        vecs[12] = '{4'b1001, 32'h0000_0025, 32'h1234_5680, 0,           1'b0, 32'h0};
        vecs[13] = '{4'b1000, 32'h0000_0025, 32'h0,         0,           1'b1, 32'hFFFF_FF80};
        vecs[14] = '{4'b1010, 32'h0000_1020, 32'h0,         DIRTY_STALL, 1'b1, 32'hBEEF_0020};
        vecs[15] = '{4'b1010, 32'h0000_1024, 32'h0,         0,           1'b1, 32'h0000_8024};

        bus.READ_WRITE = 4'b0000;
        bus.ADDRESS    = 32'h0;
        bus.WRITEDATA  = 32'h0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("reset_busy", 32'(bus.BUSYWAIT), 32'd0);
        checkOutput("reset_rdata", bus.READDATA, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;

        // Directed table
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].rw, vecs[i].addr, vecs[i].wdata, stall, rd);
            checkOutput($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
            if (vecs[i].chk_rd)
                checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
        end
        idleCheck("idle_after_table", 32'h0000_8024);

        // Reset while a fetch is in flight
        @(negedge CLK);
        bus.READ_WRITE = 4'b1010;
        bus.ADDRESS    = 32'h0000_0040;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        checkOutput("midfetch_reset_busy", 32'(bus.BUSYWAIT), 32'd0);
        checkOutput("midfetch_reset_rdata", bus.READDATA, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        bus.READ_WRITE = 4'b0000;
        applyStimulus(4'b1010, 32'h0000_0040, 32'h0, stall, rd);
        checkOutput("after_reset_stall", 32'(stall), 32'(CLEAN_STALL));
        checkOutput("after_reset_rdata", rd, 32'h0000_0040);

        // Request changes mid-miss: first fill completes, then new request misses
        @(negedge CLK);
        bus.READ_WRITE = 4'b1010;
        bus.ADDRESS    = 32'h0000_0200;
        stall = 0;
        repeat (2) begin
            @(posedge CLK);
            stall++;
        end
        @(negedge CLK);
        bus.ADDRESS = 32'h0000_0210;
        #1;
        while (bus.BUSYWAIT && stall < STALL_LIMIT) begin
            @(posedge CLK);
            stall++;
            @(negedge CLK);
            #1;
        end
        checkOutput("change_midmiss_stall", 32'(stall), 32'(2 * CLEAN_STALL));
        checkOutput("change_midmiss_rdata", bus.READDATA, 32'h0000_0210);
        @(posedge CLK);
        applyStimulus(4'b1010, 32'h0000_0200, 32'h0, stall, rd);
        checkOutput("first_fill_kept_stall", 32'(stall), 32'd0);
        checkOutput("first_fill_kept_rdata", rd, 32'h0000_0200);

        // Random phase against the functional model
        @(negedge CLK);
        bus.READ_WRITE = 4'b0000;
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        modelReset();
        tags[0] = 24'h000000;
        tags[1] = 24'h000001;
        tags[2] = 24'h000010;
        tags[3] = 24'h000023;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                idleCheck($sformatf("rand%0d_idle", n), m_last_rd);
            end else begin
                rw    = {1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
                addr  = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 3)),
                         2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
                wdata = $urandom;
                modelAccess(rw, addr, wdata, exp_stall, exp_rd);
                applyStimulus(rw, addr, wdata, stall, rd);
                checkOutput($sformatf("rand%0d_stall", n), 32'(stall), 32'(exp_stall));
                if (!rw[0])
                    checkOutput($sformatf("rand%0d_rdata", n), rd, exp_rd);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
